// File: rtl/face_sched_pkg.sv
// Shared types and constants for the face-detection frame scheduler.
package face_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } sched_state_e;

  typedef enum logic [1:0] {
    STAT_OK    = 2'd0,
    STAT_SIZE  = 2'd1,
    STAT_ABORT = 2'd2
  } frame_stat_e;

  // Below this frame edge the detection filter height collapses to zero.
  localparam int unsigned MIN_SIZE_DEFAULT = 32'd72;

  // Width of tile row/column coordinates handed to the cores.
  localparam int unsigned TILE_W = 32'd8;
  typedef logic [TILE_W-1:0] tile_t;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/face_core_scheduler_rr_pick.sv
// Round-robin first-free finder: picks the lowest free core at or after
// the pointer, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 32'd8,
  parameter int unsigned PW = (N > 32'd1) ? $clog2(N) : 32'd1
) (
  input  logic [N-1:0]  free_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned    cand;
  logic [PW-1:0]  cand_idx;

  // Scan N candidates starting at ptr_i; the first free one wins.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 32'd0;
    cand_idx = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand     = (32'(ptr_i) + off) % N;
      cand_idx = PW'(cand);
      if (!valid_o && free_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/face_core_scheduler.sv
// Frame-level scheduler: validates a frame job, walks its tile grid in
// raster order, hands tiles to free detection cores round-robin and
// accumulates the number of tiles reporting a face.
module face_core_scheduler
  import face_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES = 32'd8,
  parameter int unsigned TILES_X   = 32'd6,
  parameter int unsigned TILES_Y   = 32'd6,
  parameter int unsigned MIN_SIZE  = MIN_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic [31:0]          size,
  input  logic                 abort,
  output logic                 busy,
  output logic                 frame_done,
  output logic [1:0]           frame_status,
  output logic [15:0]          face_count,
  output logic [NUM_CORES-1:0] core_start,
  output logic [7:0]           core_tile_row,
  output logic [7:0]           core_tile_col,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_face,
  output logic                 proto_err
);

  localparam int unsigned PW = (NUM_CORES > 32'd1) ? $clog2(NUM_CORES) : 32'd1;
  localparam tile_t LAST_COL = tile_t'(TILES_X - 32'd1);
  localparam tile_t LAST_ROW = tile_t'(TILES_Y - 32'd1);
  localparam logic [PW-1:0] LAST_CORE = PW'(NUM_CORES - 32'd1);

  sched_state_e           state_q;
  frame_stat_e            stat_q;
  logic [31:0]            size_q;
  tile_t                  row_q;
  tile_t                  col_q;
  logic [NUM_CORES-1:0]   busy_mask_q;
  logic [NUM_CORES-1:0]   busy_mask_d;
  logic [PW-1:0]          rr_ptr_q;
  logic                   abort_q;
  // Set once a frame has been accepted since reset; stray completions
  // from work started before a reset must not be reported as errors.
  logic                   armed_q;

  logic                   busy_q;
  logic                   frame_done_q;
  logic [1:0]             frame_status_q;
  logic [15:0]            face_count_q;
  logic [15:0]            face_count_d;
  logic [NUM_CORES-1:0]   core_start_q;
  tile_t                  core_tile_row_q;
  tile_t                  core_tile_col_q;
  logic                   proto_err_q;

  logic [NUM_CORES-1:0]   pick_grant_s;
  logic [PW-1:0]          pick_idx_s;
  logic                   pick_valid_s;
  logic [NUM_CORES-1:0]   face_hits_s;
  logic [15:0]            face_inc_s;
  logic                   stray_s;

  rr_pick #(
    .N  (NUM_CORES),
    .PW (PW)
  ) u_rr_pick (
    .free_i  (~busy_mask_q),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .valid_o (pick_valid_s)
  );

  // Completion bookkeeping: free finished cores, count faces, flag strays.
  always_comb begin
    face_hits_s = core_done & core_face & busy_mask_q;
    stray_s     = |(core_done & ~busy_mask_q);
    busy_mask_d = busy_mask_q & ~core_done;
    face_inc_s  = 16'd0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      face_inc_s = face_inc_s + 16'(face_hits_s[i]);
    end
    face_count_d = sat_add16(face_count_q, face_inc_s);
  end

  // Frame state machine with dispatch, tile walk and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      stat_q          <= STAT_OK;
      size_q          <= 32'd0;
      row_q           <= '0;
      col_q           <= '0;
      busy_mask_q     <= '0;
      rr_ptr_q        <= '0;
      abort_q         <= 1'b0;
      armed_q         <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_status_q  <= 2'd0;
      face_count_q    <= 16'd0;
      core_start_q    <= '0;
      core_tile_row_q <= '0;
      core_tile_col_q <= '0;
      proto_err_q     <= 1'b0;
    end else begin
      core_start_q <= '0;
      frame_done_q <= 1'b0;
      busy_mask_q  <= busy_mask_d;
      face_count_q <= face_count_d;
      if (stray_s && armed_q) begin
        proto_err_q <= 1'b1;
      end else begin
        proto_err_q <= proto_err_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            size_q       <= size;
            face_count_q <= 16'd0;
            row_q        <= '0;
            col_q        <= '0;
            proto_err_q  <= 1'b0;
            abort_q      <= 1'b0;
            stat_q       <= STAT_OK;
            armed_q      <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_CHECK;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          // An abort here wins over the size check: nothing was started.
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= ST_DRAIN;
          end else if (size_q < 32'(MIN_SIZE)) begin
            stat_q  <= STAT_SIZE;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          if (abort) begin
            abort_q <= 1'b1;
            state_q <= ST_DRAIN;
          end else if (pick_valid_s) begin
            core_start_q    <= pick_grant_s;
            core_tile_row_q <= row_q;
            core_tile_col_q <= col_q;
            busy_mask_q     <= busy_mask_d | pick_grant_s;
            rr_ptr_q        <= (pick_idx_s == LAST_CORE) ? '0 : pick_idx_s + PW'(1);
            if (col_q == LAST_COL) begin
              col_q <= '0;
              if (row_q == LAST_ROW) begin
                state_q <= ST_DRAIN;
              end else begin
                row_q <= row_q + tile_t'(1);
              end
            end else begin
              col_q <= col_q + tile_t'(1);
            end
          end else begin
            state_q <= ST_DISPATCH;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            abort_q <= 1'b1;
          end else begin
            abort_q <= abort_q;
          end
          if (busy_mask_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          frame_done_q   <= 1'b1;
          frame_status_q <= abort_q ? STAT_ABORT : stat_q;
          busy_q         <= 1'b0;
          state_q        <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign frame_status  = frame_status_q;
  assign face_count    = face_count_q;
  assign core_start    = core_start_q;
  assign core_tile_row = core_tile_row_q;
  assign core_tile_col = core_tile_col_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_face_core_scheduler.sv
// Directed bench for face_core_scheduler with a simple delayed-response
// core model driven from the main stimulus thread.
module tb_face_core_scheduler;

  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [31:0]   size;
  logic          abort;
  logic          busy;
  logic          frame_done;
  logic [1:0]    frame_status;
  logic [15:0]   face_count;
  logic [NC-1:0] core_start;
  logic [7:0]    core_tile_row;
  logic [7:0]    core_tile_col;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_face;
  logic          proto_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // core responder model
  bit resp_on = 1'b0;
  int resp_delay = 0;
  int resp_cnt[NC];
  bit resp_face[NC];
  int last_done_edge = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  face_core_scheduler #(
    .NUM_CORES (NC),
    .TILES_X   (6),
    .TILES_Y   (6),
    .MIN_SIZE  (72)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .size          (size),
    .abort         (abort),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_status  (frame_status),
    .face_count    (face_count),
    .core_start    (core_start),
    .core_tile_row (core_tile_row),
    .core_tile_col (core_tile_col),
    .core_done     (core_done),
    .core_face     (core_face),
    .proto_err     (proto_err)
  );

  // Advance one clock, sample #1 after the edge, clear one-shot inputs and
  // run the core responders (done pulses are sampled at the next edge).
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    frame_start = 1'b0;
    abort       = 1'b0;
    core_done   = '0;
    core_face   = '0;
    for (int i = 0; i < NC; i++) begin
      if (resp_cnt[i] > 0) begin
        resp_cnt[i]--;
        if (resp_cnt[i] == 0) begin
          core_done[i]   = 1'b1;
          core_face[i]   = resp_face[i];
          last_done_edge = cyc + 1;
          done_count++;
        end
      end
      if (resp_on && core_start[i]) begin
        resp_cnt[i]  = resp_delay;
        resp_face[i] = (core_tile_row == 8'd2 && core_tile_col == 8'd3) ||
                       (core_tile_row == 8'd4 && core_tile_col == 8'd1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; abort = 1'b0; size = 32'd0;
    core_done = '0; core_face = '0;
    tick(); tick();
    checks++;
    if ({busy, frame_done, frame_status, face_count, core_start, core_tile_row,
         core_tile_col, proto_err} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h required 0", {busy, frame_done, frame_status,
               face_count, core_start, core_tile_row, core_tile_col, proto_err});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_size_error();
    int start_cyc, done_at, starts;
    logic [1:0] st;
    size = 32'd64; frame_start = 1'b1; start_cyc = cyc;
    done_at = -1; starts = 0; st = 2'd3;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (core_start != '0) starts++;
      if (cyc == start_cyc + 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL size_busy: got %0b required 1", busy); end
      end
      if (frame_done && done_at < 0) begin done_at = cyc; st = frame_status; end
    end
    checks++;
    if (starts != 0) begin errors++; $display("FAIL size_no_start: got %0d required 0", starts); end
    checks++;
    if (done_at != start_cyc + 3) begin
      errors++; $display("FAIL size_done_time: got %0d required %0d", done_at, start_cyc + 3);
    end
    checks++;
    if (st !== 2'd1) begin errors++; $display("FAIL size_status: got %0d required 1", st); end
  endtask

  task automatic test_normal_frame();
    int start_cyc, done_at, first_start, tiles;
    logic [7:0] er, ec;
    logic [1:0] st;
    logic [15:0] fc;
    resp_on = 1'b1; resp_delay = 50; done_count = 0;
    size = 32'd256; frame_start = 1'b1; start_cyc = cyc;
    done_at = -1; first_start = -1; tiles = 0; st = 2'd3; fc = 16'hDEAD;
    for (int n = 0; n < 2000 && done_at < 0; n++) begin
      tick();
      if (core_start != '0) begin
        er = 8'(tiles / 6);
        ec = 8'(tiles % 6);
        checks++;
        if (!$onehot(core_start) || core_tile_row !== er || core_tile_col !== ec) begin
          errors++;
          $display("FAIL raster_tile%0d: got start=%0h (%0d,%0d) required one-hot (%0d,%0d)",
                   tiles, core_start, core_tile_row, core_tile_col, er, ec);
        end
        if (first_start < 0) first_start = cyc;
        tiles++;
      end
      if (frame_done) begin done_at = cyc; st = frame_status; fc = face_count; end
    end
    checks++;
    if (first_start != start_cyc + 3) begin
      errors++; $display("FAIL first_start_time: got %0d required %0d", first_start, start_cyc + 3);
    end
    checks++;
    if (tiles != 36) begin errors++; $display("FAIL tile_count: got %0d required 36", tiles); end
    checks++;
    if (done_at < 0 || done_at != last_done_edge + 2) begin
      errors++; $display("FAIL normal_done_time: got %0d required %0d", done_at, last_done_edge + 2);
    end
    checks++;
    if (st !== 2'd0) begin errors++; $display("FAIL normal_status: got %0d required 0", st); end
    checks++;
    if (fc !== 16'd2) begin errors++; $display("FAIL normal_faces: got %0d required 2", fc); end
    checks++;
    if (done_count != 36) begin errors++; $display("FAIL normal_dones: got %0d required 36", done_count); end
  endtask

  task automatic test_proto_err();
    resp_on = 1'b0;
    core_done = 8'h08; core_face = 8'h08;
    tick();
    checks++;
    if (proto_err !== 1'b1 || face_count !== 16'd2) begin
      errors++; $display("FAIL proto_set: got err=%0b faces=%0d required err=1 faces=2", proto_err, face_count);
    end
    tick(); tick(); tick();
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %0b required 1", proto_err); end
  endtask

  task automatic test_abort();
    int start_cyc, done_at, tiles;
    logic [1:0] st;
    resp_on = 1'b1; resp_delay = 20; done_count = 0;
    size = 32'd256; frame_start = 1'b1; start_cyc = cyc;
    done_at = -1; tiles = 0; st = 2'd3;
    for (int n = 0; n < 1000 && done_at < 0; n++) begin
      tick();
      if (cyc == start_cyc + 1) begin
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear: got %0b required 0", proto_err); end
      end
      if (core_start != '0) begin
        tiles++;
        if (tiles == 10) abort = 1'b1;
      end
      if (frame_done) begin done_at = cyc; st = frame_status; end
    end
    checks++;
    if (tiles != 10) begin errors++; $display("FAIL abort_starts: got %0d required 10", tiles); end
    checks++;
    if (done_count != 10) begin errors++; $display("FAIL abort_dones: got %0d required 10", done_count); end
    checks++;
    if (done_at < 0 || done_at != last_done_edge + 2) begin
      errors++; $display("FAIL abort_done_time: got %0d required %0d", done_at, last_done_edge + 2);
    end
    checks++;
    if (st !== 2'd2) begin errors++; $display("FAIL abort_status: got %0d required 2", st); end
    checks++;
    if (face_count !== 16'd0) begin errors++; $display("FAIL abort_faces: got %0d required 0", face_count); end
  endtask

  task automatic test_back_to_back_rr();
    int start_cyc, done_at, tiles;
    logic [NC-1:0] eg;
    logic [1:0] st;
    // fresh pointer, then five grants leave it at core 5
    reset = 1'b1; tick(); reset = 1'b0; tick();
    resp_on = 1'b1; resp_delay = 20;
    size = 32'd256; frame_start = 1'b1; start_cyc = cyc;
    done_at = -1; tiles = 0; st = 2'd3;
    for (int n = 0; n < 500 && done_at < 0; n++) begin
      tick();
      if (core_start != '0) begin
        eg = 8'b1 << tiles;
        checks++;
        if (core_start !== eg || cyc != start_cyc + 3 + tiles) begin
          errors++; $display("FAIL rr_seed%0d: got %0h at %0d required %0h at %0d",
                             tiles, core_start, cyc, eg, start_cyc + 3 + tiles);
        end
        tiles++;
        if (tiles == 5) abort = 1'b1;
      end
      if (frame_done) begin done_at = cyc; st = frame_status; end
    end
    checks++;
    if (done_at < 0 || st !== 2'd2) begin
      errors++; $display("FAIL rr_seed_status: got %0d required 2", st);
    end

    // all cores free, pointer at 5: eight back-to-back grants 5,6,7,0..4
    resp_on = 1'b0;
    size = 32'd256; frame_start = 1'b1;
    tick(); tick();
    for (int t = 0; t < 8; t++) begin
      tick();
      eg = 8'b1 << ((5 + t) % 8);
      checks++;
      if (core_start !== eg || core_tile_row !== 8'(t / 6) || core_tile_col !== 8'(t % 6)) begin
        errors++; $display("FAIL rr_grant%0d: got %0h (%0d,%0d) required %0h (%0d,%0d)", t,
                           core_start, core_tile_row, core_tile_col, eg, t / 6, t % 6);
      end
    end
    tick();
    checks++;
    if (core_start !== 8'h00) begin errors++; $display("FAIL rr_all_busy: got %0h required 0", core_start); end

    // every core completes with a face in the same cycle
    core_done = 8'hFF; core_face = 8'hFF;
    tick();
    checks++;
    if (face_count !== 16'd8 || core_start !== 8'h00) begin
      errors++; $display("FAIL burst_faces: got faces=%0d start=%0h required 8 and 0", face_count, core_start);
    end
    tick();
    checks++;
    if (core_start !== 8'h20 || core_tile_row !== 8'd1 || core_tile_col !== 8'd2) begin
      errors++; $display("FAIL regrant: got %0h (%0d,%0d) required 20 (1,2)", core_start, core_tile_row, core_tile_col);
    end

    // reset in the middle of dispatch
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, frame_done, frame_status, face_count, core_start, core_tile_row,
         core_tile_col, proto_err} !== 47'd0) begin
      errors++;
      $display("FAIL midframe_reset: got %0h required 0", {busy, frame_done, frame_status,
               face_count, core_start, core_tile_row, core_tile_col, proto_err});
    end
    reset = 1'b0;
    core_done = 8'h20; core_face = 8'h20;
    tick(); tick();
    checks++;
    if (proto_err !== 1'b0 || face_count !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL late_done_ignored: got err=%0b faces=%0d busy=%0b required 0 0 0",
                         proto_err, face_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_size_error();
    test_normal_frame();
    test_proto_err();
    test_abort();
    test_back_to_back_rr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/face_core_scheduler.md
# face_core_scheduler

Frame-level scheduler for the face-detection manycore array. It accepts one frame job, checks the frame size and splits the frame into a raster grid of core tiles. It dispatches each tile to the next free face-detection core with round-robin fairness, collects each core's completion and face flag, and reports a per-frame face-tile count. It sits between the host/frame loader and the array of detection cores, and it is the only block that pulses core start.

## Interface
Parameters:
- NUM_CORES, 8: number of detection cores served.
- TILES_X, 6: tiles per frame row.
- TILES_Y, 6: tile rows per frame.
- MIN_SIZE, 72: smallest legal frame edge in pixels. Below this the core filter height collapses to 0.

Ports:
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high; clears all state.
- frame_start  in  1  one-cycle request to process a frame; only sampled in IDLE.
- size  in  32  frame edge in pixels; sampled with frame_start.
- abort  in  1  stop dispatching the current frame.
- busy  out  1  high from CHECK through DONE.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_status  out  2  0 = ok, 1 = size error, 2 = aborted; valid with frame_done and held.
- face_count  out  16  number of tiles reporting a face; held until next accepted frame_start.
- core_start  out  NUM_CORES  one-hot one-cycle start pulse.
- core_tile_row  out  8  tile row for the core being started; valid with core_start.
- core_tile_col  out  8  tile column for the core being started; valid with core_start.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse; any number may pulse in one cycle.
- core_face  in  NUM_CORES  face-found qualifier; valid with core_done.
- proto_err  out  1  sticky; cleared by reset or an accepted frame_start.

## Operation
- States: IDLE, CHECK, DISPATCH, DRAIN, DONE.
- IDLE:
  - frame_start accepted → capture size, clear face_count, tile index, proto_err and the abort latch → CHECK.
- CHECK (1 cycle):
  - size < MIN_SIZE → DONE with status 1, no core started.
  - Otherwise → DISPATCH.
- DISPATCH:
  - Each cycle, if any core is free, grant one core: the first free core at or after rr_ptr, wrapping modulo NUM_CORES.
  - Pulse that core's core_start and drive the current (row, col). Mark the core busy and set rr_ptr to grant+1 mod NUM_CORES.
  - Advance col; at col == TILES_X−1, wrap col to 0 and increment row.
  - After tile (TILES_Y−1, TILES_X−1) is dispatched → DRAIN.
- DRAIN:
  - Wait until all cores are free → DONE.
- DONE (1 cycle):
  - Pulse frame_done → IDLE.
- Completion handling runs in every state:
  - A core_done on a busy core frees it.
  - face_count increments by the popcount of core_done & core_face & busy_mask, saturating at 0xFFFF.
  - A core_done on a non-busy core is ignored and sets proto_err.
- Abort:
  - abort in CHECK or DISPATCH sets the abort latch and stops dispatch → DRAIN.
  - The frame then ends with status 2 once outstanding cores finish.
  - abort in IDLE, DRAIN or DONE is ignored, except that abort in DRAIN still sets status 2.
- frame_start outside IDLE is ignored.
- The rr_ptr value is kept across frames and cleared only by reset.

## Timing
- Reset values: busy=0, frame_done=0, frame_status=0, face_count=0, core_start=0, core_tile_row=0, core_tile_col=0, proto_err=0, rr_ptr=0, busy_mask=0, state IDLE.
- All outputs are registered.
- frame_start sampled at edge k:
  - CHECK after edge k.
  - DISPATCH after edge k+1.
  - First core_start visible after edge k+2.
- Maximum dispatch rate is one tile per cycle.
- A core freed by core_done at edge n can be granted in the decision made at edge n+1, not edge n.
- A freed core and a new dispatch may coincide in the same cycle on different cores.
- frame_done occurs one cycle after the last busy bit clears.
- With at least TILES_X·TILES_Y cores free and no stalls, frame_done follows the last core_done by 2 cycles.
- Reset mid-frame: all state returns to reset values at the next edge, and core_done pulses arriving after that are ignored without setting proto_err.

## Structure
- Shared package face_sched_pkg holds:
  - the state enum;
  - status codes STAT_OK, STAT_SIZE, STAT_ABORT;
  - the MIN_SIZE default;
  - tile coordinate width.
- Sub-module rr_pick: combinational round-robin first-free finder.
  - Inputs: free mask and rr_ptr.
  - Outputs: grant one-hot, grant index, valid.
- Everything else (state register, tile counters, busy_mask, popcount accumulator) stays in face_core_scheduler.

## Test plan
- size=256, cores respond 50 cycles after start, core_face set on tiles (2,3) and (4,1):
  - 36 core_start pulses in raster order;
  - frame_done with status 0 and face_count=2.
- size=64:
  - no core_start;
  - frame_done 2 cycles after frame_start with status 1.
- NUM_CORES=8, all cores free, rr_ptr=5:
  - first grants go to cores 5, 6, 7, 0, 1, … in consecutive cycles.
- abort after 10 dispatches, cores respond 20 cycles later:
  - no 11th core_start;
  - frame_done after the 10th core_done with status 2.
- core_done pulsed on an idle core:
  - proto_err=1, face_count unchanged, sticky until next frame_start.
- All 8 cores pulse core_done and core_face in one cycle:
  - face_count += 8;
  - reset asserted mid-DISPATCH clears every output next edge.
